// File: rtl/block_fifo_pkg.sv
// rtl/block_fifo_pkg.sv - shared widths, FSM states and cooldown length for the block_fifo write engine
package block_fifo_pkg;

  localparam int FIFO_SIZE_WIDTH = 24;
  localparam int TIMER_WIDTH     = 16;
  localparam int COOLDOWN_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

endpackage

// File: rtl/block_fifo_idle_timer.sv
// rtl/block_fifo_idle_timer.sv - 16-bit saturating idle timer with clear/enable and terminal flag
module block_fifo_idle_timer
  import block_fifo_pkg::*;
#(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam bit ENABLED = (LIMIT != 0);
  // Terminal fires during the LIMIT-th consecutive enabled cycle; limits beyond the
  // counter range collapse onto the saturation value.
  localparam logic [TIMER_WIDTH-1:0] TERM =
    (LIMIT > 65536) ? {TIMER_WIDTH{1'b1}} : TIMER_WIDTH'(LIMIT - 1);

  logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != {TIMER_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_terminal = ENABLED && i_enable && (cnt_q == TERM);

endmodule

// File: rtl/block_fifo_writer.sv
// rtl/block_fifo_writer.sv - converts a valid/ready word stream into block_fifo acquire/strobe/release writes
module block_fifo_writer
  import block_fifo_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_last,
  output logic                       o_ready,
  input  logic                       i_fifo_rdy,
  output logic                       o_fifo_act,
  input  logic [FIFO_SIZE_WIDTH-1:0] i_fifo_size,
  output logic                       o_fifo_stb,
  output logic [DATA_WIDTH-1:0]      o_fifo_data,
  input  logic                       i_fifo_starved,
  output logic                       o_busy,
  output logic [31:0]                o_block_count
);

  state_e                     state_q, state_d;
  logic                       act_q, act_d;
  logic                       stb_q, stb_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [FIFO_SIZE_WIDTH-1:0] count_q, count_d;
  logic [FIFO_SIZE_WIDTH-1:0] size_q, size_d;
  logic                       last_q, last_d;
  logic [31:0]                blk_q, blk_d;
  logic [1:0]                 cool_q, cool_d;

  logic                       xfer;
  logic                       partial;
  logic                       timer_en;
  logic                       timer_clr;
  logic                       timeout_hit;
  logic                       starve_hit;
  logic                       full_hit;
  logic [FIFO_SIZE_WIDTH-1:0] count_inc;

  assign o_ready    = (state_q == ST_WRITE) && act_q && (count_q < size_q) && !last_q;
  assign xfer       = i_valid && o_ready;
  assign count_inc  = count_q + 1'b1;
  assign partial    = (count_q != '0);
  assign full_hit   = xfer && (count_inc == size_q);
  assign starve_hit = (state_q == ST_WRITE) && partial && !i_valid && i_fifo_starved;
  assign timer_en   = (state_q == ST_WRITE) && partial && !xfer;
  assign timer_clr  = xfer || (state_q != ST_WRITE);

  block_fifo_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (timer_clr),
    .i_enable   (timer_en),
    .o_terminal (timeout_hit)
  );

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    stb_d   = 1'b0;
    data_d  = data_q;
    count_d = count_q;
    size_d  = size_q;
    last_d  = last_q;
    blk_d   = blk_q;
    cool_d  = cool_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_enable && i_fifo_rdy) begin
          act_d   = 1'b1;
          size_d  = i_fifo_size;
          count_d = '0;
          last_d  = 1'b0;
          // An empty block skips WRITE so act is high for exactly one cycle.
          state_d = (i_fifo_size == '0) ? ST_RELEASE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (xfer) begin
          stb_d   = 1'b1;
          data_d  = i_data;
          count_d = count_inc;
          if (i_last) last_d = 1'b1;
        end
        if (full_hit || (xfer && i_last) || timeout_hit || starve_hit || (size_q == '0)) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Act drops one edge after entering here, so the final strobe is always seen first.
        act_d   = 1'b0;
        blk_d   = blk_q + 1'b1;
        cool_d  = '0;
        state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cool_q == 2'(COOLDOWN_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cool_d = cool_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      act_q   <= 1'b0;
      stb_q   <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      size_q  <= '0;
      last_q  <= 1'b0;
      blk_q   <= '0;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      count_q <= count_d;
      size_q  <= size_d;
      last_q  <= last_d;
      blk_q   <= blk_d;
      cool_q  <= cool_d;
    end
  end

  assign o_fifo_act    = act_q;
  assign o_fifo_stb    = stb_q;
  assign o_fifo_data   = data_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_block_count = blk_q;

endmodule

// File: tb/tb_block_fifo_writer.sv
// tb/tb_block_fifo_writer.sv - randomized self-checking bench for block_fifo_writer
module tb_block_fifo_writer;

  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int BLK     = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_last = 1'b0;
  logic          o_ready;
  logic          i_fifo_rdy = 1'b1;
  logic          o_fifo_act;
  logic [23:0]   i_fifo_size = 24'd256;
  logic          o_fifo_stb;
  logic [DW-1:0] o_fifo_data;
  logic          i_fifo_starved = 1'b0;
  logic          o_busy;
  logic [31:0]   o_block_count;

  int total = 0;
  int bad   = 0;

  // Reader-side observations, written only by the monitor while out of reset.
  int            cyc = 0;
  logic [DW-1:0] got_q[$];
  int            stb_cyc[$];
  int            fall_cyc[$];
  int            blk_sizes[$];
  int            hi_len[$];
  int            viol = 0;
  int            cur_blk = 0;
  int            rise_cyc = 0;
  logic          act_prev = 1'b0;

  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  block_fifo_writer #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (i_enable),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .i_last         (i_last),
    .o_ready        (o_ready),
    .i_fifo_rdy     (i_fifo_rdy),
    .o_fifo_act     (o_fifo_act),
    .i_fifo_size    (i_fifo_size),
    .o_fifo_stb     (o_fifo_stb),
    .o_fifo_data    (o_fifo_data),
    .i_fifo_starved (i_fifo_starved),
    .o_busy         (o_busy),
    .o_block_count  (o_block_count)
  );

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      act_prev = 1'b0;
      cur_blk  = 0;
    end else begin
      if (o_fifo_stb) begin
        got_q.push_back(o_fifo_data);
        stb_cyc.push_back(cyc);
        cur_blk++;
      end
      if (o_fifo_stb && !o_fifo_act) viol++;
      if (o_fifo_act && !act_prev) rise_cyc = cyc;
      if (!o_fifo_act && act_prev) begin
        blk_sizes.push_back(cur_blk);
        fall_cyc.push_back(cyc);
        hi_len.push_back(cyc - rise_cyc);
        cur_blk = 0;
      end
      act_prev = o_fifo_act;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    i_fifo_rdy = 1'b1; i_fifo_starved = 1'b0; i_fifo_size = 24'd256;
    @(posedge clk);
    #1;
    got_q.delete(); stb_cyc.delete(); fall_cyc.delete(); blk_sizes.delete(); hi_len.delete();
    exp_q.delete();
    viol = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_words(input int gap_max, input bit use_last);
    int idx = 0;
    int budget = 0;
    bit r;
    while (idx < exp_q.size()) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        @(negedge clk); i_valid = 1'b0; i_last = 1'b0;
        @(posedge clk); budget++;
      end
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = exp_q[idx];
      i_last  = use_last && (idx == exp_q.size() - 1);
      #1 r = o_ready;
      @(posedge clk); budget++;
      if (r) idx++;
      if (budget > 20000) begin
        total++; bad++;
        $display("FAIL send_budget sent=%0d required=%0d", idx, exp_q.size());
        break;
      end
    end
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_falls(input int n, input int budget);
    int c = 0;
    while (fall_cyc.size() < n && c < budget) begin
      @(negedge clk); #1; c++;
    end
    total++;
    if (fall_cyc.size() < n) begin
      bad++;
      $display("FAIL wait_release releases=%0d required=%0d", fall_cyc.size(), n);
    end
  endtask

  task automatic check_data(input string name);
    int errs = 0;
    if (got_q.size() != exp_q.size()) errs++;
    else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) errs++;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL %s received=%0d words (%0d mismatches) required=%0d words in order",
               name, got_q.size(), errs, exp_q.size());
    end
  endtask

  task automatic check_sizes(input string name, input int words, input int blk);
    int rem = words;
    int k = 0;
    while (rem > 0) begin
      int e;
      e = (rem > blk) ? blk : rem;
      total++;
      if (k >= blk_sizes.size() || blk_sizes[k] !== e) begin
        bad++;
        $display("FAIL %s block%0d size=%0d required=%0d", name, k,
                 (k < blk_sizes.size()) ? blk_sizes[k] : -1, e);
      end
      rem -= e; k++;
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; i_enable = 1'b1; i_valid = 1'b1;
    #3;
    check_int("rst_act", int'(o_fifo_act), 0);
    check_int("rst_stb", int'(o_fifo_stb), 0);
    check_int("rst_ready", int'(o_ready), 0);
    check_int("rst_busy", int'(o_busy), 0);
    check_int("rst_data", int'(o_fifo_data), 0);
    check_int("rst_blkcnt", int'(o_block_count), 0);
    i_valid = 1'b0;
  endtask

  task automatic test_full_block();
    do_reset();
    for (int i = 0; i < BLK; i++) exp_q.push_back(DW'(i));
    i_enable = 1'b1;
    send_words(0, 1'b0);
    wait_falls(1, 50);
    check_sizes("full_size", BLK, BLK);
    check_data("full_data");
    if (fall_cyc.size() > 0 && stb_cyc.size() > 0)
      check_int("full_act_after_stb", fall_cyc[0] - stb_cyc[stb_cyc.size()-1], 1);
    check_int("full_blkcnt", int'(o_block_count), 1);
    check_int("full_protocol", viol, 0);
  endtask

  task automatic test_multi_block();
    int n = 600;
    do_reset();
    for (int i = 0; i < n; i++) exp_q.push_back(DW'(i));
    i_enable = 1'b1;
    send_words(3, 1'b0);
    i_fifo_starved = 1'b1;
    wait_falls((n + BLK - 1) / BLK, 200);
    i_fifo_starved = 1'b0;
    check_sizes("multi_size", n, BLK);
    check_data("multi_data");
    check_int("multi_blkcnt", int'(o_block_count), (n + BLK - 1) / BLK);
    check_int("multi_protocol", viol, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2 * BLK; i++) exp_q.push_back($urandom);
    i_enable = 1'b1;
    send_words(0, 1'b0);
    wait_falls(2, 50);
    check_data("b2b_data");
    if (stb_cyc.size() > BLK)
      check_int("b2b_overhead", stb_cyc[BLK] - stb_cyc[BLK-1] - 1, 4);
    check_int("b2b_blkcnt", int'(o_block_count), 2);
  endtask

  task automatic test_last();
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back($urandom);
    i_enable = 1'b1;
    send_words(2, 1'b1);
    wait_falls(1, 50);
    check_sizes("last_size", 10, BLK);
    check_data("last_data");
    if (fall_cyc.size() > 0 && stb_cyc.size() > 0)
      check_int("last_act_after_stb", fall_cyc[0] - stb_cyc[stb_cyc.size()-1], 1);
    check_int("last_blkcnt", int'(o_block_count), 1);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back($urandom);
    i_enable = 1'b1;
    send_words(2, 1'b0);
    wait_falls(1, 3 * TIMEOUT + 10);
    check_sizes("tmo_size", 5, BLK);
    check_data("tmo_data");
    // Act must stay high for exactly TIMEOUT idle cycles after the 5th strobe.
    if (fall_cyc.size() > 0 && stb_cyc.size() == 5)
      check_int("tmo_idle_cycles", fall_cyc[0] - stb_cyc[4] - 1, TIMEOUT);
    check_int("tmo_blkcnt", int'(o_block_count), 1);
  endtask

  task automatic test_zero_size();
    do_reset();
    i_fifo_size = 24'd0;
    i_enable = 1'b1;
    wait_falls(1, 20);
    i_enable = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_int("zero_strobes", got_q.size(), 0);
    if (hi_len.size() > 0) check_int("zero_act_len", hi_len[0], 1);
    check_int("zero_blkcnt", int'(o_block_count), 1);
    check_int("zero_busy", int'(o_busy), 0);
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 100; i++) exp_q.push_back($urandom);
    i_enable = 1'b1;
    send_words(1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_int("midrst_act", int'(o_fifo_act), 0);
    check_int("midrst_stb", int'(o_fifo_stb), 0);
    check_int("midrst_ready", int'(o_ready), 0);
    check_int("midrst_busy", int'(o_busy), 0);
    check_int("midrst_blkcnt", int'(o_block_count), 0);
    do_reset();
    for (int i = 0; i < BLK; i++) exp_q.push_back($urandom);
    i_enable = 1'b1;
    send_words(2, 1'b0);
    wait_falls(1, 50);
    check_sizes("midrst_size", BLK, BLK);
    check_data("midrst_data");
    check_int("midrst_blkcnt_after", int'(o_block_count), 1);
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_multi_block();
    test_back_to_back();
    test_last();
    test_timeout();
    test_zero_size();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
